// File: rtl/param_morph_engine.sv
// N-channel state-parameter morpher: a writable NSTATE x NCH table of signed
// parameters, with instant, linear or exponential morphs of all outputs toward a selected row.
module param_morph_engine #(
  parameter int W         = 18,
  parameter int NCH       = 8,
  parameter int NSTATE    = 8,
  parameter int RESET_VAL = 0,
  localparam int SW = (NSTATE > 1) ? $clog2(NSTATE) : 1,
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clk_en,
  input  logic [SW-1:0]       state_select,
  input  logic                retrigger,
  input  logic [1:0]          mode,
  input  logic [15:0]         ramp_dur,
  input  logic [3:0]          exp_shift,
  input  logic                tbl_we,
  input  logic [SW-1:0]       tbl_state,
  input  logic [CW-1:0]       tbl_ch,
  input  logic [W-1:0]        tbl_wdata,
  output logic [NCH*W-1:0]    out_flat,
  output logic                transitioning,
  output logic [15:0]         progress,
  output logic [SW-1:0]       from_state,
  output logic [SW-1:0]       to_state,
  output logic                done_pulse
);

  // (tgt - start) needs W+1 bits and the tick count 17 signed bits.
  localparam int PW = W + 18;

  typedef enum logic {IDLE, RAMP} fsm_t;
  typedef enum logic {KIND_LIN, KIND_EXP} kind_t;
  typedef logic signed [W-1:0] chan_t;
  typedef chan_t row_t [NCH];

  localparam chan_t RV = chan_t'(RESET_VAL);

  row_t        tbl [NSTATE];
  row_t        out_q, out_d;
  row_t        start_q, start_d;
  row_t        tgt, cap_row;
  row_t        lin_val, exp_val;
  logic [NCH-1:0] exp_eq;

  fsm_t        state_q, state_d;
  kind_t       kind_q, kind_d;
  logic [15:0] t_q, t_d;
  logic [15:0] dur_q, dur_d;
  logic [15:0] tn, prog_lin, prog_d;
  logic [3:0]  shift_q, shift_d;
  logic [SW-1:0] from_d, to_d;
  logic        trans_d, done_d, capture;

  // Target row is read live every tick; the capture row reads the table before
  // any write landing on the same clk, since both come from registered storage.
  assign tgt     = tbl[to_state];
  assign cap_row = tbl[state_select];

  assign tn       = t_q + 16'd1;
  assign prog_lin = 16'((32'(tn) * 32'd65535) / 32'(dur_q));
  assign capture  = (state_select != to_state) || retrigger;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic signed [PW-1:0] delta, prod, quo;
    logic signed [W:0]    diff, step;

    always_comb begin
      delta = PW'(tgt[c]) - PW'(start_q[c]);
      prod  = delta * $signed({1'b0, tn});
      quo   = prod / $signed({1'b0, dur_q});
      diff  = (W+1)'(tgt[c]) - (W+1)'(out_q[c]);
      step  = diff >>> shift_q;
    end

    // Signed division truncates toward zero, which is the rounding the lerp wants.
    assign lin_val[c] = chan_t'(PW'(start_q[c]) + quo);
    assign exp_val[c] = (step == '0) ? tgt[c] : chan_t'((W+1)'(out_q[c]) + step);
    assign exp_eq[c]  = (exp_val[c] == tgt[c]);
    assign out_flat[c*W +: W] = out_q[c];
  end

  // NOTE: every variable gets its hold value first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    out_d   = out_q;
    start_d = start_q;
    t_d     = t_q;
    dur_d   = dur_q;
    shift_d = shift_q;
    from_d  = from_state;
    to_d    = to_state;
    trans_d = transitioning;
    prog_d  = progress;
    done_d  = 1'b0;

    if (clk_en) begin
      if (capture) begin
        start_d = out_q;
        from_d  = to_state;
        to_d    = state_select;
        t_d     = '0;
        prog_d  = '0;
        kind_d  = (mode == 2'd2) ? KIND_EXP : KIND_LIN;
        dur_d   = (ramp_dur == '0) ? 16'd1 : ramp_dur;
        shift_d = exp_shift;
        if (mode == 2'd0) begin
          out_d   = cap_row;
          prog_d  = 16'hFFFF;
          trans_d = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          trans_d = 1'b1;
          state_d = RAMP;
        end
      end else if (state_q == RAMP) begin
        if (kind_q == KIND_LIN) begin
          t_d = tn;
          if (tn == dur_q) begin
            out_d   = tgt;
            prog_d  = 16'hFFFF;
            trans_d = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            out_d  = lin_val;
            prog_d = prog_lin;
          end
        end else begin
          out_d = exp_val;
          if (&exp_eq) begin
            prog_d  = 16'hFFFF;
            trans_d = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
    end
  end

  // NOTE: the parameter table is cleared by rst like any other state, because
  // its contents after reset are architecturally defined as RESET_VAL.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NSTATE; s++) begin
        for (int c = 0; c < NCH; c++) begin
          tbl[s][c] <= RV;
        end
      end
    end else if (tbl_we) begin
      tbl[tbl_state][tbl_ch] <= tbl_wdata;
    end
  end

  // NOTE: sequential state uses non-blocking assignment so every register
  // samples the pre-edge value of every other.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      kind_q        <= KIND_LIN;
      t_q           <= '0;
      dur_q         <= 16'd1;
      shift_q       <= '0;
      from_state    <= '0;
      to_state      <= '0;
      transitioning <= 1'b0;
      progress      <= 16'hFFFF;
      done_pulse    <= 1'b0;
      for (int c = 0; c < NCH; c++) begin
        out_q[c]   <= RV;
        start_q[c] <= RV;
      end
    end else begin
      state_q       <= state_d;
      kind_q        <= kind_d;
      t_q           <= t_d;
      dur_q         <= dur_d;
      shift_q       <= shift_d;
      from_state    <= from_d;
      to_state      <= to_d;
      transitioning <= trans_d;
      progress      <= prog_d;
      done_pulse    <= done_d;
      out_q         <= out_d;
      start_q       <= start_d;
    end
  end

endmodule
